// File: rtl/logs_pwm_capture.sv
// PWM audio receiver: 2-flop sync, box-car integration over 2^WIN_LOG2 clocks,
// and a small valid/ready sample FIFO with a sticky overflow flag.
module logs_pwm_capture #(
  parameter int WIN_LOG2   = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pwm_in,
  input  logic                  enable,
  output logic [WIN_LOG2:0]     sample_data,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow,
  input  logic                  clear_ovf
);

  localparam int SW    = WIN_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] PTR_FULL = PW'(1) << DEPTH_LOG2;

  logic                sync1;
  logic                pwm_s;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [SW-1:0]       acc;
  logic [SW-1:0]       push_val;
  logic                terminal;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [SW-1:0]       mem [DEPTH];
  logic                full;
  logic                pop;
  logic                push_ok;
  logic                drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      pwm_s <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      pwm_s <= sync1;
    end
  end

  // The terminal cycle's own pwm_s is folded into the pushed value, so exactly
  // 2^WIN_LOG2 clocks contribute while acc never needs more than WIN_LOG2 bits.
  assign terminal = enable && (win_cnt == '1);
  assign push_val = acc + SW'(pwm_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
      acc     <= '0;
    end else if (!enable || terminal) begin
      win_cnt <= '0;
      acc     <= '0;
    end else begin
      win_cnt <= win_cnt + 1'b1;
      acc     <= push_val;
    end
  end

  assign full    = ((wr_ptr ^ rd_ptr) == PTR_FULL);
  assign pop     = sample_valid && sample_ready;
  assign push_ok = terminal && (!full || pop);
  assign drop    = terminal && full && !pop;

  // A push into a full FIFO with a pop lands in the slot being popped this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_val;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (clear_ovf) overflow <= 1'b0;
  end

  assign sample_valid = (fifo_level != '0);
  assign sample_data  = mem[rd_ptr[DEPTH_LOG2-1:0]];

endmodule

// File: tb/tb_logs_pwm_capture.sv
// Bench for logs_pwm_capture: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_logs_pwm_capture;
  localparam int WIN = 256;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwm_in = 1'b0;
  logic       enable = 1'b0;
  logic       sample_ready = 1'b0;
  logic       clear_ovf = 1'b0;
  logic [8:0] sample_data;
  logic       sample_valid;
  logic [2:0] fifo_level;
  logic       overflow;

  int total = 0;
  int bad = 0;

  logs_pwm_capture #(.WIN_LOG2(8), .DEPTH_LOG2(2)) dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .enable(enable),
    .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .fifo_level(fifo_level),
    .overflow(overflow), .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: pwm seen by the integrator is pwm_in from two edges back;
  // a sample is the sum over WIN consecutive enabled clocks.
  bit m_h1, m_h2;
  int m_n, m_sum;
  int m_q[$];
  bit m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_h1 = 0; m_h2 = 0; m_n = 0; m_sum = 0; m_ovf = 0;
      m_q.delete();
    end else begin
      bit s, pop, push, dropped;
      int val;
      s = m_h2;
      m_h2 = m_h1;
      m_h1 = pwm_in;
      push = 0; val = 0;
      if (enable) begin
        m_n++;
        m_sum += s;
        if (m_n == WIN) begin
          push = 1; val = m_sum; m_n = 0; m_sum = 0;
        end
      end else begin
        m_n = 0; m_sum = 0;
      end
      pop = (m_q.size() > 0) && sample_ready;
      if (pop) void'(m_q.pop_front());
      dropped = 0;
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(val);
        else dropped = 1;
      end
      if (dropped) m_ovf = 1;
      else if (clear_ovf) m_ovf = 0;
    end
  end

  int popped[$];

  always @(negedge clk) begin
    chk("valid", sample_valid, (m_q.size() > 0));
    chk("level", fifo_level, m_q.size());
    chk("overflow", overflow, m_ovf);
    if (sample_valid && m_q.size() > 0) chk("data", sample_data, m_q[0]);
    if (sample_valid && sample_ready) popped.push_back(sample_data);
  end

  int pwm_mode = 0;
  int phase = 0;
  bit rdy_rand = 0;

  task automatic step();
    @(posedge clk);
    #1;
    case (pwm_mode)
      0: pwm_in = 1'b1;
      1: pwm_in = 1'b0;
      2: begin pwm_in = (phase == 0); phase = (phase + 1) % 4; end
      default: pwm_in = 1'($urandom_range(0, 1));
    endcase
    if (rdy_rand) sample_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_popped(input string name, input int cnt, input int val);
    chk({name, "_count"}, popped.size(), cnt);
    foreach (popped[i]) chk({name, "_value"}, popped[i], val);
  endtask

  // Restart windows cleanly with a new pwm source (sync pipeline pre-filled).
  task automatic restart(input int mode);
    enable = 1'b0;
    pwm_mode = mode;
    steps(4);
    popped.delete();
    enable = 1'b1;
  endtask

  initial begin
    int waited;
    sample_ready = 1'b1;
    #12;
    chk("rst_valid", sample_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", sample_data, 0);
    rst_n = 1'b1;
    steps(2);

    restart(0);
    steps(3 * WIN + 4);
    check_popped("const1", 3, 256);

    restart(1);
    steps(2 * WIN + 4);
    check_popped("const0", 2, 0);

    restart(2);
    steps(2 * WIN + 4);
    check_popped("pat1000", 2, 64);

    // five windows with no consumer: four kept, the fifth dropped
    restart(0);
    sample_ready = 1'b0;
    steps(5 * WIN + 3);
    chk("ovf_level", fifo_level, 4);
    chk("ovf_flag", overflow, 1);
    enable = 1'b0;
    sample_ready = 1'b1;
    steps(10);
    check_popped("drain", 4, 256);
    chk("drain_valid", sample_valid, 0);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    step();
    chk("ovf_cleared", overflow, 0);

    // enable dropped at win_cnt=100 discards the partial window
    restart(0);
    steps(100);
    enable = 1'b0;
    steps(10);
    enable = 1'b1;
    steps(WIN - 2);
    chk("en_gap_early", popped.size(), 0);
    steps(6);
    check_popped("en_gap", 1, 256);

    // full FIFO with a pop exactly on the terminal cycle
    restart(0);
    sample_ready = 1'b0;
    steps(5 * WIN - 1);
    chk("full_pre_level", fifo_level, 4);
    chk("full_pre_ovf", overflow, 0);
    sample_ready = 1'b1;
    step();
    sample_ready = 1'b0;
    #4;
    chk("pushpop_level", fifo_level, 4);
    chk("pushpop_ovf", overflow, 0);
    steps(WIN - 1);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    #4;
    chk("clr_vs_drop_ovf", overflow, 1);

    // reset mid-window with three samples queued
    restart(0);
    sample_ready = 1'b1;
    steps(8);
    sample_ready = 1'b0;
    steps(3 * WIN + 50);
    chk("pre_rst_level", fifo_level, 3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", sample_valid, 0);
    chk("rst_mid_level", fifo_level, 0);
    chk("rst_mid_ovf", overflow, 0);
    steps(3);
    rst_n = 1'b1;
    waited = 0;
    while (!sample_valid && waited < 600) begin
      step();
      waited++;
    end
    chk("post_rst_arrived", sample_valid, 1);
    chk("post_rst_late", (waited >= WIN - 1), 1);

    // randomized traffic
    rst_n = 1'b1;
    pwm_mode = 3;
    rdy_rand = 1'b1;
    for (int blk = 0; blk < 30; blk++) begin
      enable = ($urandom_range(0, 9) != 0);
      clear_ovf = ($urandom_range(0, 7) == 0);
      steps($urandom_range(20, 150));
    end
    clear_ovf = 1'b0;
    steps(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=%0d expected=%0d", 1, 0);
    $fatal(1);
  end

endmodule
